parameter_bank: RTL and testbench

- Parametrised successor to the MIDI control-change parameter register block.
- Maps MIDI CC messages onto N_PARAMS generic parameter slots of 14 bits each, filtered by MIDI channel.
- Holds N_PRESETS snapshot presets: a STORE_PRESET CC saves the live slots into a preset; a Program Change reloads them, one slot per cycle.
- Sits between the MIDI decoder and the synth voice/envelope/mixer blocks.

---
 rtl/parameter_bank_pkg.sv | 64 ++++++
 rtl/parameter_preset_store.sv | 38 +++
 rtl/parameter_bank.sv | 136 +++++++++++++
 tb/tb_parameter_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/parameter_bank_pkg.sv
// parameter_bank_pkg: MIDI message types and parameter-slot constants shared by the parameter bank
//   package MIDI      : message_t, message_type_t, controller numbers
//   package PARAMETER : PARAM_W, slot_t, PARAM_DEFAULTS, STORE_PRESET, cc_to_slot, bank_state_t
package MIDI;

    typedef enum logic [2:0] {
        NOTE_OFF, NOTE_ON, POLY_PRESSURE, CONTROL_CHANGE,
        PROGRAM_CHANGE, CHANNEL_PRESSURE, PITCH_BEND, SYSTEM
    } message_type_t;

    typedef struct packed {
        message_type_t message_type;
        logic [3:0]    channel;
        logic [6:0]    data_byte1;
        logic [6:0]    data_byte2;
    } message_t;

    localparam logic [6:0] CC_VOLUME  = 7'd7;
    localparam logic [6:0] CC_TEMPO   = 7'd14;
    localparam logic [6:0] CC_UNISON  = 7'd15;
    localparam logic [6:0] CC_ATTACK  = 7'd16;
    localparam logic [6:0] CC_DECAY   = 7'd17;
    localparam logic [6:0] CC_SUSTAIN = 7'd18;
    localparam logic [6:0] CC_RELEASE = 7'd19;

endpackage

package PARAMETER;

    import MIDI::*;

    localparam int PARAM_W = 14;

    typedef logic [PARAM_W-1:0] slot_t;

    localparam slot_t PARAM_DEFAULTS [32] = '{
        0: 14'h2000, 1: 14'h0000, 2: 14'h0400, 3: 14'h0800,
        4: 14'h3000, 5: 14'h1000, 6: 14'h2000, 7: 14'h0100,
        default: 14'h0000
    };

    localparam logic [6:0] STORE_PRESET = 7'd85;

    typedef enum logic [1:0] {IDLE, LOAD, STORE} bank_state_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] slot;
    } cc_map_t;

    function automatic cc_map_t cc_to_slot(input logic [6:0] controller);
        case (controller)
            CC_TEMPO:   return '{1'b1, 5'd0};
            CC_UNISON:  return '{1'b1, 5'd1};
            CC_ATTACK:  return '{1'b1, 5'd2};
            CC_DECAY:   return '{1'b1, 5'd3};
            CC_SUSTAIN: return '{1'b1, 5'd4};
            CC_RELEASE: return '{1'b1, 5'd5};
            CC_VOLUME:  return '{1'b1, 5'd6};
            default:    return '{1'b0, 5'd0};
        endcase
    endfunction

endpackage

// File: rtl/parameter_preset_store.sv
// parameter_preset_store: N_PRESETS x N_PARAMS snapshot array of 14-bit slots
//   clk_i, rst_i       : clock, synchronous active-high reset (all entries -> PARAM_DEFAULTS)
//   we_i, wr_*_i       : synchronous write port addressed by {preset, idx}
//   rd_*_i, rd_data_o  : combinational read port addressed by {preset, idx}
module parameter_preset_store
    import PARAMETER::*;
#(
    parameter int N_PARAMS  = 8,
    parameter int N_PRESETS = 4,
    localparam int IW = N_PARAMS  > 1 ? $clog2(N_PARAMS)  : 1,
    localparam int PW = N_PRESETS > 1 ? $clog2(N_PRESETS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [PW-1:0] wr_preset_i,
    input  logic [IW-1:0] wr_idx_i,
    input  slot_t         wr_data_i,
    input  logic [PW-1:0] rd_preset_i,
    input  logic [IW-1:0] rd_idx_i,
    output slot_t         rd_data_o
);

    slot_t mem_q [N_PRESETS][N_PARAMS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < N_PRESETS; p++)
                for (int i = 0; i < N_PARAMS; i++)
                    mem_q[p][i] <= PARAM_DEFAULTS[i];
        end else if (we_i) begin
            mem_q[wr_preset_i][wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_preset_i][rd_idx_i];

endmodule

// File: rtl/parameter_bank.sv
// parameter_bank: channel-filtered MIDI CC -> parameter slots with preset store/recall
//   clock_50_000_000, reset : clock, synchronous active-high reset
//   message, message_valid  : decoded MIDI message and its one-cycle strobe
//   params                  : live slots, slot i at [14i+13:14i]
//   param_updated           : per-slot strobe, high when the new value first shows on params
//   busy                    : preset load/store walking the slots
//   dropped                 : accepted-channel message discarded because busy
// Build option: PARAMETER_BANK_CC14_EN enables 14-bit MSB/LSB controller pairs (c, c+32).
module parameter_bank
    import MIDI::*;
    import PARAMETER::*;
#(
    parameter int N_PARAMS  = 8,
    parameter int N_PRESETS = 4,
    parameter int CHANNEL   = 0,
    parameter int OMNI      = 0
) (
    input  logic                        clock_50_000_000,
    input  logic                        reset,
    input  message_t                    message,
    input  logic                        message_valid,
    output logic [N_PARAMS*PARAM_W-1:0] params,
    output logic [N_PARAMS-1:0]         param_updated,
    output logic                        busy,
    output logic                        dropped
);

    localparam int IW = N_PARAMS  > 1 ? $clog2(N_PARAMS)  : 1;
    localparam int PW = N_PRESETS > 1 ? $clog2(N_PRESETS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_PARAMS - 1);
    localparam logic [7:0]    NPRE = 8'(N_PRESETS);
    localparam logic [5:0]    NPAR = 6'(N_PARAMS);

    bank_state_t   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] preset_q, preset_d;
    slot_t         params_q [N_PARAMS];
    logic [N_PARAMS-1:0] updated_q;
    logic          dropped_q;
    logic          fire, idle, is_cc, start_store, start_load, cc_we;
    logic [IW-1:0] cc_slot;
    slot_t         cc_val, rd_data;
    cc_map_t       map;

    assign fire  = message_valid && (OMNI != 0 || message.channel == 4'(CHANNEL));
    assign idle  = state_q == IDLE;
    assign is_cc = fire && idle && message.message_type == CONTROL_CHANGE;
    assign start_store = is_cc && message.data_byte1 == STORE_PRESET
                         && {1'b0, message.data_byte2} < NPRE;
    assign start_load  = fire && idle && message.message_type == PROGRAM_CHANGE
                         && {1'b0, message.data_byte1} < NPRE;

`ifdef PARAMETER_BANK_CC14_EN
    // Controllers 32..63 are the LSB half of controller c-32 and only touch bits [6:0].
    logic lsb;
    assign lsb    = message.data_byte1[6:5] == 2'b01;
    assign map    = cc_to_slot(lsb ? {2'b00, message.data_byte1[4:0]} : message.data_byte1);
    assign cc_val = lsb ? {params_q[cc_slot][13:7], message.data_byte2} : {message.data_byte2, 7'b0};
`else
    assign map    = cc_to_slot(message.data_byte1);
    assign cc_val = {message.data_byte2, 7'b0};
`endif
    assign cc_slot = map.slot[IW-1:0];
    assign cc_we   = is_cc && map.hit && {1'b0, map.slot} < NPAR;

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            preset_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            preset_q <= preset_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        preset_d = preset_q;
        if (idle) begin
            if (start_store || start_load) begin
                state_d  = start_store ? STORE : LOAD;
                idx_d    = '0;
                preset_d = start_store ? message.data_byte2[PW-1:0] : message.data_byte1[PW-1:0];
            end
        end else if (idx_q == LAST) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_comb busy = !idle;

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            for (int i = 0; i < N_PARAMS; i++) params_q[i] <= PARAM_DEFAULTS[i];
            updated_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            updated_q <= '0;
            dropped_q <= fire && !idle;
            if (cc_we) begin
                params_q[cc_slot]  <= cc_val;
                updated_q[cc_slot] <= 1'b1;
            end
            if (state_q == LOAD) begin
                params_q[idx_q]  <= rd_data;
                updated_q[idx_q] <= 1'b1;
            end
        end
    end

    parameter_preset_store #(.N_PARAMS(N_PARAMS), .N_PRESETS(N_PRESETS)) u_store (
        .clk_i       (clock_50_000_000),
        .rst_i       (reset),
        .we_i        (state_q == STORE),
        .wr_preset_i (preset_q),
        .wr_idx_i    (idx_q),
        .wr_data_i   (params_q[idx_q]),
        .rd_preset_i (preset_q),
        .rd_idx_i    (idx_q),
        .rd_data_o   (rd_data)
    );

    for (genvar g = 0; g < N_PARAMS; g++) begin : g_out
        assign params[PARAM_W*g +: PARAM_W] = params_q[g];
    end

    assign param_updated = updated_q;
    assign dropped       = dropped_q;

endmodule

// File: tb/tb_parameter_bank.sv
// tb_parameter_bank: scoreboard bench for parameter_bank (CHANNEL=3; plain, OMNI and N_PARAMS=1 instances)
module tb_parameter_bank;
    import MIDI::*;
    import PARAMETER::*;

    localparam logic [3:0] CH = 4'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, valid = 1'b0;
    message_t msg = '{NOTE_ON, CH, 7'd0, 7'd0};

    logic [111:0] params, params_o;
    logic [7:0]   upd, upd_o;
    logic         busy, dropped, busy_o, dropped_o;
    logic [13:0]  params_1;
    logic [0:0]   upd_1;
    logic         busy_1, dropped_1;

    parameter_bank #(.N_PARAMS(8), .N_PRESETS(4), .CHANNEL(3), .OMNI(0)) dut (
        .clock_50_000_000(clk), .reset(rst), .message(msg), .message_valid(valid),
        .params(params), .param_updated(upd), .busy(busy), .dropped(dropped));

    parameter_bank #(.N_PARAMS(8), .N_PRESETS(4), .CHANNEL(3), .OMNI(1)) dut_omni (
        .clock_50_000_000(clk), .reset(rst), .message(msg), .message_valid(valid),
        .params(params_o), .param_updated(upd_o), .busy(busy_o), .dropped(dropped_o));

    parameter_bank #(.N_PARAMS(1), .N_PRESETS(2), .CHANNEL(3), .OMNI(0)) dut_one (
        .clock_50_000_000(clk), .reset(rst), .message(msg), .message_valid(valid),
        .params(params_1), .param_updated(upd_1), .busy(busy_1), .dropped(dropped_1));

    logic [13:0] DEF [8] = '{14'h2000, 14'h0000, 14'h0400, 14'h0800,
                             14'h3000, 14'h1000, 14'h2000, 14'h0100};

    logic [13:0] m_params [8];
    logic [13:0] m_pre [4][8];
    int m_state = 0, m_idx = 0, m_p = 0;

    typedef struct {
        logic [111:0] p;
        logic [7:0]   u;
        logic         b;
        logic         d;
    } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0;

    function automatic logic [111:0] flat(input logic [13:0] a [8]);
        logic [111:0] f;
        for (int i = 0; i < 8; i++) f[14*i +: 14] = a[i];
        return f;
    endfunction

    function automatic int tb_slot(input logic [6:0] c);
        if (c == CC_TEMPO)   return 0;
        if (c == CC_UNISON)  return 1;
        if (c == CC_ATTACK)  return 2;
        if (c == CC_DECAY)   return 3;
        if (c == CC_SUSTAIN) return 4;
        if (c == CC_RELEASE) return 5;
        if (c == CC_VOLUME)  return 6;
        return -1;
    endfunction

    function automatic message_t cc(input logic [6:0] c, input logic [6:0] v, input logic [3:0] ch);
        return '{CONTROL_CHANGE, ch, c, v};
    endfunction

    function automatic message_t pc(input logic [6:0] p, input logic [3:0] ch);
        return '{PROGRAM_CHANGE, ch, p, 7'd0};
    endfunction

    task automatic chk(input string tag, input logic [111:0] got, input logic [111:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict the DUT's next outputs, then compare after the edge.
    task automatic step(input logic r, input logic v, input message_t m);
        exp_t e;
        logic [7:0] u;
        logic d;
        int s;
        logic lsb;
        rst = r; valid = v; msg = m;
        u = '0; d = 1'b0; lsb = 1'b0;
        if (r) begin
            m_params = DEF;
            for (int p = 0; p < 4; p++) m_pre[p] = DEF;
            m_state = 0; m_idx = 0;
        end else if (m_state != 0) begin
            if (v && m.channel == CH) d = 1'b1;
            if (m_state == 1) begin
                m_params[m_idx] = m_pre[m_p][m_idx];
                u[m_idx] = 1'b1;
            end else begin
                m_pre[m_p][m_idx] = m_params[m_idx];
            end
            if (m_idx == 7) begin m_state = 0; m_idx = 0; end
            else m_idx++;
        end else if (v && m.channel == CH) begin
            if (m.message_type == CONTROL_CHANGE) begin
                if (m.data_byte1 == STORE_PRESET) begin
                    if (m.data_byte2 < 4) begin m_state = 2; m_idx = 0; m_p = int'(m.data_byte2); end
                end else begin
                    s = tb_slot(m.data_byte1);
`ifdef PARAMETER_BANK_CC14_EN
                    if (m.data_byte1 >= 32 && m.data_byte1 <= 63) begin
                        s = tb_slot(m.data_byte1 - 7'd32);
                        lsb = 1'b1;
                    end
`endif
                    if (s >= 0) begin
                        m_params[s] = lsb ? {m_params[s][13:7], m.data_byte2} : {m.data_byte2, 7'b0};
                        u[s] = 1'b1;
                    end
                end
            end else if (m.message_type == PROGRAM_CHANGE && m.data_byte1 < 4) begin
                m_state = 1; m_idx = 0; m_p = int'(m.data_byte1);
            end
        end
        e.p = flat(m_params); e.u = u; e.b = m_state != 0; e.d = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("params", params, e.p);
        chk("param_updated", 112'(upd), 112'(e.u));
        chk("busy", 112'(busy), 112'(e.b));
        chk("dropped", 112'(dropped), 112'(e.d));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '{NOTE_ON, CH, 7'd0, 7'd0});
    endtask

    task automatic send(input message_t m);
        step(1'b0, 1'b1, m);
    endtask

    initial begin
        int nb;
        step(1'b1, 1'b0, msg);
        step(1'b1, 1'b0, msg);
        chk("reset_params", params, flat(DEF));
        chk("reset_busy", 112'(busy), 112'(0));

        send(cc(CC_ATTACK, 7'h40, CH));
        chk("t1_slot2", 112'(params[28 +: 14]), 112'(14'h2000));
        chk("t1_upd", 112'(upd), 112'(8'b0000_0100));
        idle(1);
        chk("t1_upd_clear", 112'(upd), 112'(0));

        send(cc(CC_VOLUME, 7'h7F, CH + 4'd1));
        chk("t2_slot6_filtered", 112'(params[84 +: 14]), 112'(14'h2000));
        chk("t2_no_drop", 112'(dropped), 112'(0));
        chk("t2_omni_slot6", 112'(params_o[84 +: 14]), 112'(14'h3F80));
        chk("t2_omni_upd", 112'(upd_o), 112'(8'h40));

        send(cc(CC_TEMPO, 7'h11, CH));
        send(cc(CC_UNISON, 7'h22, CH));
        send(cc(CC_ATTACK, 7'h33, CH));
        send(cc(CC_DECAY, 7'h44, CH));
        send(cc(CC_SUSTAIN, 7'h55, CH));
        send(cc(CC_RELEASE, 7'h66, CH));
        send(cc(CC_VOLUME, 7'h77, CH));
        send(cc(STORE_PRESET, 7'd2, CH));
        nb = int'(busy);
        for (int k = 0; k < 8; k++) begin idle(1); nb += int'(busy); end
        chk("t3_store_busy_cycles", 112'(nb), 112'(8));
        send(cc(CC_TEMPO, 7'h01, CH));
        chk("t3_slot0_changed", 112'(params[0 +: 14]), 112'(14'h0080));
        send(pc(7'd2, CH));
        chk("t3_load_upd0", 112'(upd), 112'(0));
        nb = int'(busy);
        for (int k = 0; k < 8; k++) begin
            idle(1);
            nb += int'(busy);
            chk("t3_upd_walk", 112'(upd), 112'(8'd1 << k));
        end
        chk("t3_load_busy_cycles", 112'(nb), 112'(8));
        chk("t3_slot0_restored", 112'(params[0 +: 14]), 112'(14'h0880));

        send(pc(7'd1, CH));
        send(cc(CC_TEMPO, 7'h7F, CH));
        chk("t4_dropped", 112'(dropped), 112'(1));
        idle(1);
        chk("t4_dropped_once", 112'(dropped), 112'(0));
        idle(6);
        chk("t4_tempo_default", 112'(params[0 +: 14]), 112'(14'h2000));
        send(pc(7'd9, CH));
        chk("t4_pc9_ignored", 112'(busy), 112'(0));

        send(pc(7'd2, CH));
        idle(2);
        step(1'b1, 1'b0, msg);
        chk("t5_reset_busy", 112'(busy), 112'(0));
        chk("t5_reset_params", params, flat(DEF));
        send(pc(7'd2, CH));
        idle(8);
        chk("t5_preset_defaults", params, flat(DEF));

        send(pc(7'd0, CH));
        chk("n1_busy", 112'(busy_1), 112'(1));
        idle(1);
        chk("n1_busy_fall", 112'(busy_1), 112'(0));
        chk("n1_upd", 112'(upd_1), 112'(1));
        idle(7);

`ifdef PARAMETER_BANK_CC14_EN
        send(cc(CC_ATTACK, 7'h12, CH));
        chk("t6_msb", 112'(params[28 +: 14]), 112'(14'h0900));
        send(cc(CC_ATTACK + 7'd32, 7'h34, CH));
        chk("t6_lsb", 112'(params[28 +: 14]), 112'(14'h0934));
        chk("t6_lsb_upd", 112'(upd), 112'(8'b0000_0100));
        send(cc(CC_ATTACK, 7'h01, CH));
        chk("t6_msb_clears_lsb", 112'(params[28 +: 14]), 112'(14'h0080));
`else
        send(cc(CC_ATTACK + 7'd32, 7'h34, CH));
        chk("t6_cc48_miss", 112'(params[28 +: 14]), 112'(14'h0400));
        chk("t6_cc48_no_upd", 112'(upd), 112'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
